// File: rtl/reduce_engine.sv
// Streaming block reducer: folds up to BLOCK_LEN beats of LANES words into one
// wrapping-sum, signed-max or signed-min result, with sum overflow detection.
module reduce_engine #(
    parameter int DATA_W    = 32,
    parameter int LANES     = 2,
    parameter int BLOCK_LEN = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         mode,
    input  logic                               flush,
    input  logic [LANES*DATA_W-1:0]            in_data,
    input  logic                               in_valid,
    input  logic                               in_last,
    output logic                               in_ready,
    output logic [DATA_W-1:0]                  out_data,
    output logic [$clog2(BLOCK_LEN+1)-1:0]     out_count,
    output logic                               out_ovf,
    output logic                               out_valid,
    input  logic                               out_ready
);

    localparam int CNT_W = $clog2(BLOCK_LEN + 1);
    localparam int ACC_W = DATA_W + $clog2(LANES * BLOCK_LEN);

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [CNT_W-1:0]    out_count_q;
    logic                out_ovf_q;
    logic                out_valid_q;

    logic [DATA_W-1:0]   lane_w [LANES];
    logic [1:0]          op;
    logic                op_max;
    logic                op_min;
    logic [ACC_W-1:0]    beat_sum;
    logic [DATA_W-1:0]   beat_max;
    logic [DATA_W-1:0]   beat_min;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   max_fold;
    logic [DATA_W-1:0]   min_fold;
    logic [ACC_W-1:0]    acc_d;
    logic [CNT_W-1:0]    count_d;
    logic                ovf_d;
    logic                accept;
    logic                complete;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_w[gi] = in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // The first beat of a block uses the live mode; later beats use the latched one.
    assign op     = (state_q == S_IDLE) ? mode : mode_q;
    assign op_max = (op == 2'b01);
    assign op_min = (op == 2'b10);

    always_comb begin
        beat_sum = ACC_W'(lane_w[0]);
        beat_max = lane_w[0];
        beat_min = lane_w[0];
        for (int k = 1; k < LANES; k++) begin
            beat_sum = beat_sum + ACC_W'(lane_w[k]);
            if ($signed(lane_w[k]) > $signed(beat_max)) begin
                beat_max = lane_w[k];
            end
            if ($signed(lane_w[k]) < $signed(beat_min)) begin
                beat_min = lane_w[k];
            end
        end
    end

    assign acc_lo   = acc_q[DATA_W-1:0];
    assign max_fold = ($signed(beat_max) > $signed(acc_lo)) ? beat_max : acc_lo;
    assign min_fold = ($signed(beat_min) < $signed(acc_lo)) ? beat_min : acc_lo;

    always_comb begin
        acc_d = '0;
        if (state_q == S_IDLE) begin
            if (op_max) begin
                acc_d = ACC_W'(beat_max);
            end else if (op_min) begin
                acc_d = ACC_W'(beat_min);
            end else begin
                acc_d = beat_sum;
            end
        end else begin
            if (op_max) begin
                acc_d = ACC_W'(max_fold);
            end else if (op_min) begin
                acc_d = ACC_W'(min_fold);
            end else begin
                acc_d = acc_q + beat_sum;
            end
        end
    end

    assign count_d  = (state_q == S_IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
    // The shift form stays legal when ACC_W == DATA_W (single lane, single beat).
    assign ovf_d    = !op_max && !op_min && ((acc_d >> DATA_W) != '0);
    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (count_d == CNT_W'(BLOCK_LEN)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'b00;
            acc_q       <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (flush) begin
                state_q <= S_IDLE;
                acc_q   <= '0;
                count_q <= '0;
            end else if (accept) begin
                if (state_q == S_IDLE) begin
                    mode_q <= mode;
                end
                if (complete) begin
                    state_q     <= S_IDLE;
                    acc_q       <= '0;
                    count_q     <= '0;
                    out_data_q  <= acc_d[DATA_W-1:0];
                    out_count_q <= count_d;
                    out_ovf_q   <= ovf_d;
                    out_valid_q <= 1'b1;
                end else begin
                    state_q <= S_ACCUM;
                    acc_q   <= acc_d;
                    count_q <= count_d;
                end
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reduce_engine.sv
// Self-checking bench for reduce_engine (DATA_W=8, LANES=2, BLOCK_LEN=4):
// directed scenarios plus randomized blocks against a queue-based reference model.
module tb_reduce_engine;

    localparam int DW = 8;
    localparam int LN = 2;
    localparam int BL = 4;
    localparam int CW = $clog2(BL + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              flush = 1'b0;
    logic [LN*DW-1:0]  in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_count;
    logic              out_ovf;
    logic              out_valid;
    logic              out_ready = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;
    int qa[$];
    int qb[$];

    reduce_engine #(.DATA_W(DW), .LANES(LN), .BLOCK_LEN(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Offers one beat and returns 1 time unit after the edge that accepted it.
    task automatic drive_beat(input int a, input int b, input logic last, input logic [1:0] m);
        int waited;
        waited   = 0;
        in_data  = {b[7:0], a[7:0]};
        in_valid = 1'b1;
        in_last  = last;
        mode     = m;
        #1;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        tests_run++;
        if (waited >= 20) begin
            tests_failed++;
            $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        qa.push_back(a);
        qb.push_back(b);
    endtask

    // Reference: reduce every lane word of the collected block using plain integer arithmetic.
    task automatic model_result(input logic [1:0] m, output logic [7:0] d, output logic o);
        int s, mx, mn, v;
        s  = 0;
        mx = -129;
        mn = 128;
        for (int i = 0; i < qa.size(); i++) begin
            for (int l = 0; l < 2; l++) begin
                v = (l == 0) ? qa[i] : qb[i];
                s += v;
                if (v > 127) v -= 256;
                if (v > mx) mx = v;
                if (v < mn) mn = v;
            end
        end
        if (m == 2'b01) begin
            d = mx[7:0]; o = 1'b0;
        end else if (m == 2'b10) begin
            d = mn[7:0]; o = 1'b0;
        end else begin
            d = s[7:0]; o = (s > 255);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        tests_run++; if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %02h want 00", out_data); end
        tests_run++; if (out_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", out_count); end
        tests_run++; if (out_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0b want 0", out_ovf); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_valid: got %0b want 0", out_valid); end
        $display("[TB] reset done");
    endtask

    task automatic test_sum_full();
        out_ready = 1'b1;
        qa.delete(); qb.delete();
        for (int i = 0; i < 4; i++) drive_beat(2*i + 1, 2*i + 2, 1'b0, 2'b00);
        $display("[TB] sum_full data=%02h count=%0d ovf=%0b valid=%0b", out_data, out_count, out_ovf, out_valid);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL sum_valid: got %0b want 1", out_valid); end
        tests_run++; if (out_data !== 8'd36) begin tests_failed++; $display("FAIL sum_data: got %0d want 36", out_data); end
        tests_run++; if (out_count !== 3'd4) begin tests_failed++; $display("FAIL sum_count: got %0d want 4", out_count); end
        tests_run++; if (out_ovf !== 1'b0) begin tests_failed++; $display("FAIL sum_ovf: got %0b want 0", out_ovf); end
        @(posedge clk); #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL sum_valid_pulse: got %0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        qa.delete(); qb.delete();
        for (int i = 0; i < 4; i++) drive_beat(255, 255, 1'b0, 2'b00);
        $display("[TB] overflow data=%02h count=%0d ovf=%0b", out_data, out_count, out_ovf);
        tests_run++; if (out_data !== 8'hF8) begin tests_failed++; $display("FAIL ovf_data: got %02h want f8", out_data); end
        tests_run++; if (out_ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %0b want 1", out_ovf); end
        tests_run++; if (out_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count: got %0d want 4", out_count); end
    endtask

    task automatic test_max_min();
        logic [1:0] m1 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [1:0] m2 [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
        logic [7:0] ex [4] = '{8'h7F, 8'h80, 8'h7F, 8'h80};
        for (int c = 0; c < 4; c++) begin
            drive_beat(8'h80, 8'h05, 1'b0, m1[c]);
            drive_beat(8'hFE, 8'h7F, 1'b1, m2[c]);
            $display("[TB] maxmin case=%0d data=%02h count=%0d ovf=%0b", c, out_data, out_count, out_ovf);
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mm_valid[%0d]: got %0b want 1", c, out_valid); end
            tests_run++; if (out_data !== ex[c]) begin tests_failed++; $display("FAIL mm_data[%0d]: got %02h want %02h", c, out_data, ex[c]); end
            tests_run++; if (out_count !== 3'd2) begin tests_failed++; $display("FAIL mm_count[%0d]: got %0d want 2", c, out_count); end
            tests_run++; if (out_ovf !== 1'b0) begin tests_failed++; $display("FAIL mm_ovf[%0d]: got %0b want 0", c, out_ovf); end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_beat(1, 1, 1'b0, 2'b00);
        drive_beat(2, 2, 1'b1, 2'b00);
        in_data  = {8'd9, 8'd9};
        in_valid = 1'b1;
        in_last  = 1'b1;
        mode     = 2'b00;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++; if (out_valid !== 1'b1 || out_data !== 8'd6 || out_count !== 3'd2 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%0b d=%0d c=%0d r=%0b want v=1 d=6 c=2 r=0", i, out_valid, out_data, out_count, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %0b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("[TB] back_to_back data=%0d count=%0d valid=%0b", out_data, out_count, out_valid);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid: got %0b want 1", out_valid); end
        tests_run++; if (out_data !== 8'd18) begin tests_failed++; $display("FAIL b2b_data: got %0d want 18", out_data); end
        tests_run++; if (out_count !== 3'd1) begin tests_failed++; $display("FAIL b2b_count: got %0d want 1", out_count); end
        @(posedge clk); #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive_beat(10, 10, 1'b0, 2'b00);
        drive_beat(10, 10, 1'b0, 2'b00);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = {8'd10, 8'd10};
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_result: got %0b want 0", out_valid); end
        for (int i = 0; i < 4; i++) drive_beat(1, 1, 1'b0, 2'b00);
        $display("[TB] flush data=%0d count=%0d", out_data, out_count);
        tests_run++; if (out_data !== 8'd8) begin tests_failed++; $display("FAIL flush_data: got %0d want 8", out_data); end
        tests_run++; if (out_count !== 3'd4) begin tests_failed++; $display("FAIL flush_count: got %0d want 4", out_count); end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive_beat(5, 5, 1'b1, 2'b00);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL ar_pending: got %0b want 1", out_valid); end
        #2 rst = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 3'd0 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL ar_immediate: got v=%0b d=%02h c=%0d o=%0b want all 0", out_valid, out_data, out_count, out_ovf);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        drive_beat(1, 1, 1'b0, 2'b00);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive_beat(3, 4, 1'b1, 2'b00);
        $display("[TB] async_reset data=%0d count=%0d", out_data, out_count);
        tests_run++; if (out_data !== 8'd7) begin tests_failed++; $display("FAIL ar_data: got %0d want 7", out_data); end
        tests_run++; if (out_count !== 3'd1) begin tests_failed++; $display("FAIL ar_count: got %0d want 1", out_count); end
    endtask

    task automatic test_random();
        logic [1:0] m, mm;
        logic [7:0] ed;
        logic       eo, last;
        int         len, gap;
        out_ready = 1'b1;
        for (int blk = 0; blk < 40; blk++) begin
            m   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 4);
            qa.delete(); qb.delete();
            for (int j = 0; j < len; j++) begin
                last = (j == len - 1) ? ((len < 4) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
                mm   = (j == 0) ? m : 2'($urandom_range(0, 3));
                drive_beat($urandom_range(0, 255), $urandom_range(0, 255), last, mm);
            end
            model_result(m, ed, eo);
            $display("[TB] rand blk=%0d mode=%0d len=%0d data=%02h count=%0d ovf=%0b", blk, m, len, out_data, out_count, out_ovf);
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rnd_valid[%0d]: got %0b want 1", blk, out_valid); end
            tests_run++; if (out_data !== ed) begin tests_failed++; $display("FAIL rnd_data[%0d]: got %02h want %02h", blk, out_data, ed); end
            tests_run++; if (out_count !== 3'(len)) begin tests_failed++; $display("FAIL rnd_count[%0d]: got %0d want %0d", blk, out_count, len); end
            tests_run++; if (out_ovf !== eo) begin tests_failed++; $display("FAIL rnd_ovf[%0d]: got %0b want %0b", blk, out_ovf, eo); end
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        test_sum_full();
        test_overflow();
        test_max_min();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reduce_engine.md
# reduce_engine

Parametrised streaming reduction engine, the successor to the fixed two-accumulator sum block. It accepts LANES data words per beat over a valid/ready stream and folds each block of up to BLOCK_LEN beats into one result. The reduction is a wrapping sum, signed max or signed min, with sum overflow detection. It sits between the vector source and the result collector in the reduction datapath.

## Interface
- DATA_W, 32: width of each lane word and of the result
- LANES, 2: lane words per input beat (≥1)
- BLOCK_LEN, 1024: maximum beats per block (≥1)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- mode  input  2  00 sum, 01 signed max, 10 signed min, 11 treated as sum
- flush  input  1  synchronous discard of the partial block
- in_data  input  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]
- in_valid  input  1  beat offered
- in_last  input  1  beat closes the block early; qualified by in_valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- out_data  output  DATA_W  block result
- out_count  output  $clog2(BLOCK_LEN+1)  beats folded into the result (1..BLOCK_LEN)
- out_ovf  output  1  sum mode only: true sum exceeded DATA_W unsigned bits
- out_valid  output  1  result held until out_valid && out_ready
- out_ready  input  1  collector accepts result

## Operation
- States:
  - IDLE: no beat accepted in the current block.
  - ACCUM: block in progress.
  - Result register (out_valid) is independent of the state.
- Beat reduction is combinational per beat: all LANES words are combined with the latched mode op into one value (sum at ACC_W = DATA_W + $clog2(LANES*BLOCK_LEN) bits, zero-extended).
- First beat of a block (IDLE):
  - latches mode;
  - loads the accumulator with the beat value (no identity constant);
  - sets beat count to 1;
  - goes to ACCUM.
- mode changes during ACCUM are ignored until the next block.
- Each further accepted beat folds into the accumulator with the latched op and increments the count.
- Block completes on an accepted beat that has in_last=1 or brings the count to BLOCK_LEN. On completion:
  - out_data = acc[DATA_W-1:0];
  - out_count = count;
  - out_ovf = (sum mode && acc[ACC_W-1:DATA_W] != 0), else 0;
  - out_valid is set;
  - state returns to IDLE.
- A single-beat block (in_last on the first beat) is legal: out_count=1.
- Max/min are signed two's complement over DATA_W bits.
- flush=1:
  - discards the accumulator and count;
  - state goes to IDLE;
  - does not touch a pending result.
  - in_ready is 0 while flush=1, so flush has priority over a simultaneous beat.
- in_ready = !flush && (!out_valid || out_ready). This is a combinational path from out_ready.
- out_valid clears on handshake unless a new block completes in the same cycle; then the register reloads and out_valid stays 1.
- Reset values (asynchronous, immediate on rst low):
  - out_data=0, out_count=0, out_ovf=0, out_valid=0;
  - state IDLE, accumulator and count cleared.
  - in_ready follows its equation (1 when flush=0).

## Timing
- Latency: out_valid rises the cycle after the completing beat is accepted.
- Throughput: one beat per cycle while out_ready=1 or no result is pending.
- Backpressure: with a result pending and out_ready=0, in_ready=0. out_data, out_count and out_ovf stay stable until the handshake.
- Back-to-back blocks: the first beat of block N+1 may be accepted in the same cycle block N's result is handshaken.
- Reset mid-block drops the partial block and any pending result with no output.

## Test plan
Parameters for all scenarios: DATA_W=8, LANES=2, BLOCK_LEN=4.
- Sum, full block: beats (1,2),(3,4),(5,6),(7,8), mode=00, out_ready=1 -> one cycle after the 4th beat: out_data=36, out_count=4, out_ovf=0, out_valid for 1 cycle.
- Overflow: 4 beats of (0xFF,0xFF), sum -> true sum 0x7F8; out_data=0xF8, out_ovf=1, out_count=4.
- Early last / max-min:
  - mode=01, beats (0x80,0x05),(0xFE,0x7F with in_last) -> out_data=0x7F, out_count=2, out_ovf=0.
  - Same beats with mode=10 -> out_data=0x80.
  - Flip mode to 00 after the first beat -> result still the max/min.
- Backpressure:
  - out_ready=0 at completion -> in_ready low the next cycle; result fields frozen for 5 cycles.
  - out_ready=1 -> handshake in that cycle; in_ready=1 in the same cycle.
  - A block completing in the handshake cycle reloads the result with no gap.
- Flush: 2 beats (10,10), then flush=1 with in_valid=1 -> in_ready=0, beat dropped. Next 4 beats of (1,1) -> out_data=8, out_count=4.
- Async reset: rst low mid-block with a pending result -> all outputs 0 immediately. After release, a 1-beat in_last block (3,4) -> out_data=7, out_count=1.
